id_ex_hazard_stage: RTL and testbench
=====================================

# id_ex_hazard_stage

ID/EX pipeline register of the five-stage MIPS pipeline with integrated hazard detection and bubble insertion. Captures decoded ID-stage fields every cycle and presents them as EX-stage signals to the ALU-input and DataBusB forwarding units downstream. Detects the hazards forwarding cannot cover (load-use, and branch/jr operands resolved early in ID), stalls PC and IF/ID, and inserts bubbles. Keeps saturating stall and bubble counters for performance debug.

## Interface
Parameters:
- CNT_W, 32, width of the stall and bubble counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ID_PC_4  in  32  PC+4 of the ID instruction
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register fields
- ID_DataBusA, ID_DataBusB  in  32 each  register-file read data
- ID_Imm32  in  32  extended immediate
- ID_Shamt  in  5  shift amount
- ID_ALUFun  in  6  ALU function
- ID_ALUSrc1, ID_ALUSrc2  in  1 each  ALU operand selects
- ID_RegDst  in  2  0=Rd, 1=Rt, 2=$31, 3=$26
- ID_MemToReg  in  2  0=ALUOut, 1=MemOut, 2=PC_4
- ID_RegWr, ID_MemRd, ID_MemWr  in  1 each  write/memory controls
- ID_UsesRs, ID_UsesRt  in  1 each  instruction reads Rs/Rt in EX
- ID_IsBranch  in  1  instruction resolves branch/jr in ID (reads Rs, and Rt if ID_UsesRt)
- ID_Flush  in  1  kill instruction in ID (exception/interrupt/taken jump)
- Hold  in  1  global freeze (memory wait)
- MEM_RegWr  in  1;  MEM_MemToReg  in  2;  MEM_RegDst  in  2;  MEM_Rd, MEM_Rt  in  5 each  MEM-stage destination info
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- EX_PC_4, EX_DataBusA, EX_DataBusB, EX_Imm32  out  32 each  registered copies
- EX_Rs, EX_Rt, EX_Rd, EX_Shamt  out  5 each;  EX_ALUFun  out  6
- EX_ALUSrc1, EX_ALUSrc2, EX_RegWr, EX_MemRd, EX_MemWr, EX_Valid  out  1 each
- EX_RegDst, EX_MemToReg  out  2 each
- StallCnt, BubbleCnt  out  CNT_W each  saturating counters

## Operation
- Destination decode for EX and MEM: RegDst 0→Rd, 1→Rt, 2→31, 3→26. A destination of 0 never causes a hazard.
- Load-use hazard: EX_RegWr && EX_MemToReg==1 && destination equals ID_Rs (ID_UsesRs or ID_IsBranch) or ID_Rt (ID_UsesRt).
- Branch hazard (ID_IsBranch only):
  - EX_RegWr && EX_MemToReg∈{0,1} && destination matches a read register.
  - MEM_RegWr && MEM_MemToReg==1 && destination matches.
  - EX or MEM with MemToReg==2 is forwarded downstream and is not a hazard.
- Hazard = load-use OR branch hazard. Stall = Hazard && !ID_Flush && !Hold.
- Register update priority, per rising edge:
  1. Hold: all EX_* registers keep their values; counters unchanged.
  2. ID_Flush, or Stall: bubble. EX_RegWr, EX_MemRd, EX_MemWr and EX_Valid become 0. Other fields load from ID (don't-care).
  3. Otherwise: all fields load from ID, and EX_Valid becomes 1.
- StallCnt increments on every edge where Stall=1. BubbleCnt increments on every edge where a bubble is written. Both saturate at all-ones.
- Reset (asynchronous): every EX_* output is 0 (EX_Valid=0), both counters are 0. Stall follows its combinational inputs.

## Timing
- Latency is 1 cycle, ID→EX. Stall has zero latency (same cycle as the hazard).
- A load followed by a dependent ALU op gives 1 stall cycle.
- A load followed by a dependent branch gives 2 stall cycles: first from the EX load, then from the MEM load.
- An ALU op followed by a dependent branch gives 1 stall cycle.
- ID_Flush during a hazard: Stall=0 and a bubble is inserted. The flushed instruction never reaches EX.
- Hold with a hazard present: Stall=0 and the registers are frozen. The hazard is re-evaluated after Hold drops.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads ID normally.

## Test plan
- Load-use: lw $8 in EX (RegDst=1, Rt=8, MemToReg=1), ID add reads Rs=8 → Stall=1 for 1 cycle, EX_Valid=0 and EX_RegWr=0 next cycle, add reaches EX on the following edge; StallCnt=1, BubbleCnt=1.
- Branch after load: lw $9, then beq $9,$0 → Stall high for 2 consecutive cycles, 2 bubbles, beq issues on the 3rd edge.
- jal in EX (RegDst=2, MemToReg=2), ID jr $31 → Stall=0, jr loads directly into EX.
- Register $0: lw $0 in EX, ID reads Rs=0 → no stall.
- Flush/hold priority: load-use hazard with ID_Flush=1 → Stall=0 and bubble inserted. Hold=1 → EX_PC_4 unchanged (e.g. 0x00400008) and counters unchanged.
- Saturation with CNT_W=2: 5 consecutive stall cycles → StallCnt=3. Async reset low mid-cycle → all EX_* and both counters read 0 before the next edge.

Source files
------------

// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bundle: decoded ID fields, MEM-stage destination info and the
// registered EX-stage view, plus stall/bubble status and debug counters.
interface id_ex_hazard_stage_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ID_PC_4;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic [4:0]       ID_Rd;
    logic [31:0]      ID_DataBusA;
    logic [31:0]      ID_DataBusB;
    logic [31:0]      ID_Imm32;
    logic [4:0]       ID_Shamt;
    logic [5:0]       ID_ALUFun;
    logic             ID_ALUSrc1;
    logic             ID_ALUSrc2;
    logic [1:0]       ID_RegDst;
    logic [1:0]       ID_MemToReg;
    logic             ID_RegWr;
    logic             ID_MemRd;
    logic             ID_MemWr;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_IsBranch;
    logic             ID_Flush;
    logic             Hold;

    logic             MEM_RegWr;
    logic [1:0]       MEM_MemToReg;
    logic [1:0]       MEM_RegDst;
    logic [4:0]       MEM_Rd;
    logic [4:0]       MEM_Rt;

    logic             Stall;
    logic [31:0]      EX_PC_4;
    logic [31:0]      EX_DataBusA;
    logic [31:0]      EX_DataBusB;
    logic [31:0]      EX_Imm32;
    logic [4:0]       EX_Rs;
    logic [4:0]       EX_Rt;
    logic [4:0]       EX_Rd;
    logic [4:0]       EX_Shamt;
    logic [5:0]       EX_ALUFun;
    logic             EX_ALUSrc1;
    logic             EX_ALUSrc2;
    logic             EX_RegWr;
    logic             EX_MemRd;
    logic             EX_MemWr;
    logic             EX_Valid;
    logic [1:0]       EX_RegDst;
    logic [1:0]       EX_MemToReg;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] BubbleCnt;

    modport master (
        output ID_PC_4, ID_Rs, ID_Rt, ID_Rd, ID_DataBusA, ID_DataBusB, ID_Imm32,
               ID_Shamt, ID_ALUFun, ID_ALUSrc1, ID_ALUSrc2, ID_RegDst, ID_MemToReg,
               ID_RegWr, ID_MemRd, ID_MemWr, ID_UsesRs, ID_UsesRt, ID_IsBranch,
               ID_Flush, Hold, MEM_RegWr, MEM_MemToReg, MEM_RegDst, MEM_Rd, MEM_Rt,
        input  Stall, EX_PC_4, EX_DataBusA, EX_DataBusB, EX_Imm32, EX_Rs, EX_Rt,
               EX_Rd, EX_Shamt, EX_ALUFun, EX_ALUSrc1, EX_ALUSrc2, EX_RegWr,
               EX_MemRd, EX_MemWr, EX_Valid, EX_RegDst, EX_MemToReg, StallCnt,
               BubbleCnt
    );

    modport slave (
        input  ID_PC_4, ID_Rs, ID_Rt, ID_Rd, ID_DataBusA, ID_DataBusB, ID_Imm32,
               ID_Shamt, ID_ALUFun, ID_ALUSrc1, ID_ALUSrc2, ID_RegDst, ID_MemToReg,
               ID_RegWr, ID_MemRd, ID_MemWr, ID_UsesRs, ID_UsesRt, ID_IsBranch,
               ID_Flush, Hold, MEM_RegWr, MEM_MemToReg, MEM_RegDst, MEM_Rd, MEM_Rt,
        output Stall, EX_PC_4, EX_DataBusA, EX_DataBusB, EX_Imm32, EX_Rs, EX_Rt,
               EX_Rd, EX_Shamt, EX_ALUFun, EX_ALUSrc1, EX_ALUSrc2, EX_RegWr,
               EX_MemRd, EX_MemWr, EX_Valid, EX_RegDst, EX_MemToReg, StallCnt,
               BubbleCnt
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use and early-branch hazard detection,
// bubble insertion and saturating stall/bubble counters.
module id_ex_hazard_stage #(
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    id_ex_hazard_stage_if.slave bus
);

    function automatic logic [4:0] dest_reg(input logic [1:0] reg_dst,
                                            input logic [4:0] rd,
                                            input logic [4:0] rt);
        case (reg_dst)
            2'd0:    dest_reg = rd;
            2'd1:    dest_reg = rt;
            2'd2:    dest_reg = 5'd31;
            default: dest_reg = 5'd26;
        endcase
    endfunction

    logic [4:0]       ex_dst;
    logic [4:0]       mem_dst;
    logic             rs_read;
    logic             rt_read;
    logic             ex_match;
    logic             mem_match;
    logic             load_use;
    logic             branch_haz;
    logic             hazard;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    assign ex_dst  = dest_reg(bus.EX_RegDst, bus.EX_Rd, bus.EX_Rt);
    assign mem_dst = dest_reg(bus.MEM_RegDst, bus.MEM_Rd, bus.MEM_Rt);

    // A branch/jr always reads Rs in ID, whether or not the ALU would use it.
    assign rs_read = bus.ID_UsesRs || bus.ID_IsBranch;
    assign rt_read = bus.ID_UsesRt;

    assign ex_match  = (ex_dst != 5'd0) &&
                       ((rs_read && ex_dst == bus.ID_Rs) || (rt_read && ex_dst == bus.ID_Rt));
    assign mem_match = (mem_dst != 5'd0) &&
                       ((rs_read && mem_dst == bus.ID_Rs) || (rt_read && mem_dst == bus.ID_Rt));

    assign load_use = bus.EX_RegWr && (bus.EX_MemToReg == 2'd1) && ex_match;

    // PC_4 results (MemToReg==2) are forwarded to ID, so only ALU/memory results stall a branch.
    assign branch_haz = bus.ID_IsBranch &&
                        ((bus.EX_RegWr && !bus.EX_MemToReg[1] && ex_match) ||
                         (bus.MEM_RegWr && (bus.MEM_MemToReg == 2'd1) && mem_match));

    assign hazard    = load_use || branch_haz;
    assign stall     = hazard && !bus.ID_Flush && !bus.Hold;
    assign bubble    = !bus.Hold && (bus.ID_Flush || stall);
    assign bus.Stall = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.EX_PC_4     <= '0;
            bus.EX_DataBusA <= '0;
            bus.EX_DataBusB <= '0;
            bus.EX_Imm32    <= '0;
            bus.EX_Rs       <= '0;
            bus.EX_Rt       <= '0;
            bus.EX_Rd       <= '0;
            bus.EX_Shamt    <= '0;
            bus.EX_ALUFun   <= '0;
            bus.EX_ALUSrc1  <= 1'b0;
            bus.EX_ALUSrc2  <= 1'b0;
            bus.EX_RegDst   <= '0;
            bus.EX_MemToReg <= '0;
            bus.EX_RegWr    <= 1'b0;
            bus.EX_MemRd    <= 1'b0;
            bus.EX_MemWr    <= 1'b0;
            bus.EX_Valid    <= 1'b0;
        end else if (!bus.Hold) begin
            bus.EX_PC_4     <= bus.ID_PC_4;
            bus.EX_DataBusA <= bus.ID_DataBusA;
            bus.EX_DataBusB <= bus.ID_DataBusB;
            bus.EX_Imm32    <= bus.ID_Imm32;
            bus.EX_Rs       <= bus.ID_Rs;
            bus.EX_Rt       <= bus.ID_Rt;
            bus.EX_Rd       <= bus.ID_Rd;
            bus.EX_Shamt    <= bus.ID_Shamt;
            bus.EX_ALUFun   <= bus.ID_ALUFun;
            bus.EX_ALUSrc1  <= bus.ID_ALUSrc1;
            bus.EX_ALUSrc2  <= bus.ID_ALUSrc2;
            bus.EX_RegDst   <= bus.ID_RegDst;
            bus.EX_MemToReg <= bus.ID_MemToReg;
            bus.EX_RegWr    <= bus.ID_RegWr && !bubble;
            bus.EX_MemRd    <= bus.ID_MemRd && !bubble;
            bus.EX_MemWr    <= bus.ID_MemWr && !bubble;
            bus.EX_Valid    <= !bubble;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bus.StallCnt  = stall_cnt;
    assign bus.BubbleCnt = bubble_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed scoreboard bench for id_ex_hazard_stage: load-use, branch hazards,
// $0 and PC_4 forwarding cases, flush/hold priority, saturation and async reset.
module tb_id_ex_hazard_stage;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic        memrd;
        logic        chk;
        logic [31:0] pc4;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage_if #(.CNT_W(CNT_W)) bus ();

    id_ex_hazard_stage #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setInstr(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [1:0] regdst,
                            input logic [1:0] memtoreg, input logic regwr, input logic memrd,
                            input logic usesrs, input logic usesrt, input logic isbranch);
        bus.ID_PC_4     = pc4;
        bus.ID_Rs       = rs;
        bus.ID_Rt       = rt;
        bus.ID_Rd       = rd;
        bus.ID_DataBusA = ~pc4;
        bus.ID_DataBusB = pc4 + 32'd1;
        bus.ID_Imm32    = 32'h0000_0010;
        bus.ID_Shamt    = 5'd0;
        bus.ID_ALUFun   = 6'd0;
        bus.ID_ALUSrc1  = 1'b0;
        bus.ID_ALUSrc2  = 1'b0;
        bus.ID_RegDst   = regdst;
        bus.ID_MemToReg = memtoreg;
        bus.ID_RegWr    = regwr;
        bus.ID_MemRd    = memrd;
        bus.ID_MemWr    = 1'b0;
        bus.ID_UsesRs   = usesrs;
        bus.ID_UsesRt   = usesrt;
        bus.ID_IsBranch = isbranch;
    endtask

    task automatic setMem(input logic regwr, input logic [1:0] memtoreg, input logic [1:0] regdst,
                          input logic [4:0] rd, input logic [4:0] rt);
        bus.MEM_RegWr    = regwr;
        bus.MEM_MemToReg = memtoreg;
        bus.MEM_RegDst   = regdst;
        bus.MEM_Rd       = rd;
        bus.MEM_Rt       = rt;
    endtask

    // Checks Stall before the edge, queues the expected EX view, then compares after the edge.
    task automatic applyStimulus(input string tag, input logic exp_stall, input logic valid,
                                 input logic regwr, input logic memrd, input logic chk);
        exp_t e;
        #2;
        checkOutput({tag, "_stall"}, 32'(bus.Stall), 32'(exp_stall));
        e = '{valid, regwr, memrd, chk, bus.ID_PC_4};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, "_valid"}, 32'(bus.EX_Valid), 32'(e.valid));
        checkOutput({tag, "_regwr"}, 32'(bus.EX_RegWr), 32'(e.regwr));
        checkOutput({tag, "_memrd"}, 32'(bus.EX_MemRd), 32'(e.memrd));
        if (e.chk) begin
            checkOutput({tag, "_pc4"}, bus.EX_PC_4, e.pc4);
            checkOutput({tag, "_busa"}, bus.EX_DataBusA, ~e.pc4);
        end
    endtask

    task automatic checkCounters(input string tag, input int stalls, input int bubbles);
        checkOutput({tag, "_stallcnt"}, 32'(bus.StallCnt), 32'(stalls));
        checkOutput({tag, "_bubblecnt"}, 32'(bus.BubbleCnt), 32'(bubbles));
    endtask

    task automatic applyReset();
        bus.Hold     = 1'b0;
        bus.ID_Flush = 1'b0;
        setMem(1'b0, 2'd0, 2'd0, 5'd0, 5'd0);
        reset = 1'b0;
        #3;
        checkOutput("rst_valid", 32'(bus.EX_Valid), 32'd0);
        checkOutput("rst_pc4", bus.EX_PC_4, 32'd0);
        checkCounters("rst", 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        bus.Hold     = 1'b0;
        bus.ID_Flush = 1'b0;
        setInstr(32'h0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        setMem(1'b0, 2'd0, 2'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        checkOutput("init_regwr", 32'(bus.EX_RegWr), 32'd0);
        checkOutput("init_stall", 32'(bus.Stall), 32'd0);
        applyReset();

        // load-use: lw $8 then add reading $8
        setInstr(32'h100, 5'd1, 5'd8, 5'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("lw8", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        setInstr(32'h104, 5'd8, 5'd2, 5'd10, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("lu_bubble", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        setMem(1'b1, 2'd1, 2'd1, 5'd0, 5'd8);
        applyStimulus("lu_issue", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkCounters("lu", 1, 1);

        // lw $9 then beq $9,$0: stalls on the EX load, then on the MEM load
        applyReset();
        setInstr(32'h200, 5'd1, 5'd9, 5'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("lw9", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        setInstr(32'h204, 5'd9, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("br_bub1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        setMem(1'b1, 2'd1, 2'd1, 5'd0, 5'd9);
        applyStimulus("br_bub2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        setMem(1'b0, 2'd0, 2'd0, 5'd0, 5'd0);
        applyStimulus("br_issue", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkCounters("br", 2, 2);

        // jal then jr $31: PC_4 is forwarded, no stall
        setInstr(32'h300, 5'd0, 5'd0, 5'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("jal", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        setInstr(32'h304, 5'd31, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        setMem(1'b1, 2'd2, 2'd2, 5'd0, 5'd0);
        applyStimulus("jr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkCounters("jr", 2, 2);

        // add $5 then beq $5: one stall, counters reach saturation at 3
        setMem(1'b0, 2'd0, 2'd0, 5'd0, 5'd0);
        setInstr(32'h308, 5'd1, 5'd2, 5'd5, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("add5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        setInstr(32'h30C, 5'd5, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("alu_br_bub", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        setMem(1'b1, 2'd0, 2'd0, 5'd5, 5'd0);
        applyStimulus("alu_br_issue", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkCounters("alu_br", 3, 3);

        // lw $0 never creates a hazard
        applyReset();
        setInstr(32'h400, 5'd1, 5'd0, 5'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("lw0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        setInstr(32'h404, 5'd0, 5'd0, 5'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        setMem(1'b1, 2'd1, 2'd1, 5'd0, 5'd0);
        applyStimulus("r0_nostall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkCounters("r0", 0, 0);

        // Hold freezes EX over a pending hazard; Flush then bubbles without stalling
        applyReset();
        setInstr(32'h0040_0004, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("nop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        setInstr(32'h0040_0008, 5'd1, 5'd8, 5'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("lw8b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        setInstr(32'h0040_000C, 5'd8, 5'd0, 5'd9, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.Hold = 1'b1;
        applyStimulus("hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("hold_pc4", bus.EX_PC_4, 32'h0040_0008);
        checkCounters("hold", 0, 0);
        bus.Hold     = 1'b0;
        bus.ID_Flush = 1'b1;
        applyStimulus("flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.ID_Flush = 1'b0;
        checkCounters("flush", 0, 1);

        // persistent MEM-load branch hazard saturates both counters
        applyReset();
        setMem(1'b1, 2'd1, 2'd1, 5'd0, 5'd7);
        setInstr(32'h500, 5'd7, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus("sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCounters("sat", 3, 3);

        // async reset mid-cycle clears outputs before the next edge
        setMem(1'b0, 2'd0, 2'd0, 5'd0, 5'd0);
        setInstr(32'h504, 5'd7, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("post_sat", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_valid", 32'(bus.EX_Valid), 32'd0);
        checkOutput("async_pc4", bus.EX_PC_4, 32'd0);
        checkCounters("async", 0, 0);
        #2;
        reset = 1'b1;
        setInstr(32'h600, 5'd1, 5'd2, 5'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("after_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
